dbgu32_cmd: RTL and testbench

Byte-level command engine of the 32-bit debug unit. It sits between the debug UART receiver/transmitter and the SoC debug memory port (`dbg_mem_op`/`dbg_wren`/`dbg_adr`/`dbg_do`). It parses host command frames into word-wide memory writes and reads, returns read data as a little-endian byte stream, and controls the CPU reset line. The CPU clock is never gated, so memory access runs concurrently with a live CPU.

---
 rtl/dbgu32_cmd.sv | 157 +++++++++++++++
 tb/tb_dbgu32_cmd.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbgu32_cmd.sv
// dbgu32_cmd: byte command engine of the 32-bit debug unit.
// Parses host frames into word memory accesses and CPU reset control.
module dbgu32_cmd #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_op,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_do,
    input  logic [31:0] mem_di,
    input  logic        mem_ack,
    output logic        cpu_n_reset,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
        S_WDATA0, S_WDATA1, S_WDATA2, S_WDATA3,
        S_WRITE, S_READ,
        S_TX0, S_TX1, S_TX2, S_TX3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nrst_q, nrst_d;
    logic          tmo_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            shadow_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            nrst_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            nrst_q   <= nrst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = '0;
        nrst_d   = nrst_q;
        tmo_st   = state_q inside {S_ADDR1, S_ADDR2, S_ADDR3,
                                   S_WDATA1, S_WDATA2, S_WDATA3};
        unique case (state_q)
            S_IDLE: if (rx_valid) begin
                unique case (rx_data)
                    8'h01:   state_d = S_ADDR0;
                    8'h02:   nrst_d = 1'b0;
                    8'h03:   nrst_d = 1'b1;
                    8'h04:   state_d = S_WDATA0;
                    8'h05:   state_d = S_READ;
                    default: state_d = S_IDLE;
                endcase
            end
            S_ADDR0: if (rx_valid) begin
                shadow_d[7:0] = rx_data;
                state_d = S_ADDR1;
            end
            S_ADDR1: if (rx_valid) begin
                shadow_d[15:8] = rx_data;
                state_d = S_ADDR2;
            end
            S_ADDR2: if (rx_valid) begin
                shadow_d[23:16] = rx_data;
                state_d = S_ADDR3;
            end
            S_ADDR3: if (rx_valid) begin
                ptr_d = {rx_data, shadow_q[23:0]};
                state_d = S_IDLE;
            end
            S_WDATA0: if (rx_valid) begin
                wdata_d[7:0] = rx_data;
                state_d = S_WDATA1;
            end
            S_WDATA1: if (rx_valid) begin
                wdata_d[15:8] = rx_data;
                state_d = S_WDATA2;
            end
            S_WDATA2: if (rx_valid) begin
                wdata_d[23:16] = rx_data;
                state_d = S_WDATA3;
            end
            S_WDATA3: if (rx_valid) begin
                wdata_d[31:24] = rx_data;
                state_d = S_WRITE;
            end
            S_WRITE: if (mem_ack) begin
                ptr_d = ptr_q + 32'd4;
                state_d = S_IDLE;
            end
            S_READ: if (mem_ack) begin
                ptr_d = ptr_q + 32'd4;
                rdata_d = mem_di;
                state_d = S_TX0;
            end
            S_TX0: if (tx_ready) state_d = S_TX1;
            S_TX1: if (tx_ready) state_d = S_TX2;
            S_TX2: if (tx_ready) state_d = S_TX3;
            S_TX3: if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // an arriving byte takes priority over an expiring frame timer
        if (tmo_st && !rx_valid) begin
            if (cnt_q == TMAX) state_d = S_IDLE;
            else               cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            S_TX0:   tx_data = rdata_q[7:0];
            S_TX1:   tx_data = rdata_q[15:8];
            S_TX2:   tx_data = rdata_q[23:16];
            S_TX3:   tx_data = rdata_q[31:24];
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_valid    = state_q inside {S_TX0, S_TX1, S_TX2, S_TX3};
    assign mem_op      = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem_wren    = (state_q == S_WRITE) ? 4'hF : 4'h0;
    assign mem_adr     = ptr_q;
    assign mem_do      = wdata_q;
    assign cpu_n_reset = nrst_q;
    assign busy        = state_q != S_IDLE;

endmodule

// File: tb/tb_dbgu32_cmd.sv
// Testbench for dbgu32_cmd: command table plus scoreboarded
// memory requests and TX byte stream.
module tb_dbgu32_cmd;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_op;
    logic [3:0]  mem_wren;
    logic [31:0] mem_adr;
    logic [31:0] mem_do;
    logic [31:0] mem_di = '0;
    logic        mem_ack = 1'b0;
    logic        cpu_n_reset;
    logic        busy;

    dbgu32_cmd #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_op(mem_op), .mem_wren(mem_wren), .mem_adr(mem_adr),
        .mem_do(mem_do), .mem_di(mem_di), .mem_ack(mem_ack),
        .cpu_n_reset(cpu_n_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  wren;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        logic [7:0] b;
        logic       nrst;
    } vec_t;

    req_t       req_q[$];
    logic [7:0] txq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] c, input logic [31:0] w);
        send(c);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_txv"}, tx_valid, 0);
        chk({nm, "_txd"}, tx_data, 0);
        chk({nm, "_op"}, mem_op, 0);
        chk({nm, "_wren"}, mem_wren, 0);
        chk({nm, "_adr"}, mem_adr, 0);
        chk({nm, "_do"}, mem_do, 0);
        chk({nm, "_nrst"}, cpu_n_reset, 1);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic serve(input int waits, input logic [31:0] di);
        req_t r;
        int n = 0;
        if (req_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL serve: no expected request queued");
            return;
        end
        r = req_q.pop_front();
        while (!mem_op && n < 50) begin
            tick();
            n++;
        end
        chk("mem_op_up", mem_op, 1);
        chk("mem_adr", mem_adr, r.adr);
        chk("mem_wren", mem_wren, r.wren);
        if (r.wren != 4'h0) chk("mem_do", mem_do, r.dat);
        repeat (waits) begin
            tick();
            chk("mem_hold", {mem_op, mem_wren, mem_adr},
                {1'b1, r.wren, r.adr});
        end
        mem_ack = 1'b1;
        mem_di = di;
        tick();
        mem_ack = 1'b0;
        mem_di = '0;
        chk("mem_op_drop", mem_op, 0);
    endtask

    task automatic drain(input bit tog);
        bit         ph = 1'b0;
        bit         held = 1'b0;
        logic [7:0] hd = '0;
        int         n = 0;
        while (txq.size() != 0 && n < 40) begin
            if (held) chk("tx_hold", {tx_valid, tx_data}, {1'b1, hd});
            tx_ready = tog ? ph : 1'b1;
            if (tx_valid && tx_ready) chk("tx_byte", tx_data, txq.pop_front());
            held = tx_valid && !tx_ready;
            hd = tx_data;
            ph = ~ph;
            tick();
            n++;
        end
        tx_ready = 1'b0;
        chk("tx_drained", txq.size(), 0);
        chk("tx_end", tx_valid, 0);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [31:0] di,
                           input bit tog, input bit drop);
        req_q.push_back('{adr, 4'h0, 32'h0});
        for (int i = 0; i < 4; i++) txq.push_back(di[8*i +: 8]);
        send(8'h05);
        serve(1, di);
        chk("tx_first", tx_valid, 1);
        if (drop) send(8'h01);
        drain(tog);
        tick();
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_op", mem_op, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vt[0] = '{8'h02, 1'b0};
        vt[1] = '{8'h7E, 1'b0};
        vt[2] = '{8'h03, 1'b1};
        vt[3] = '{8'h00, 1'b1};
        vt[4] = '{8'h02, 1'b0};
        vt[5] = '{8'hFF, 1'b0};
        vt[6] = '{8'h06, 1'b0};
        vt[7] = '{8'h03, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        chk_reset("rst");

        for (int i = 0; i < 8; i++) begin
            send(vt[i].b);
            chk($sformatf("cmd%0d_nrst", i), cpu_n_reset, vt[i].nrst);
            chk($sformatf("cmd%0d_busy", i), busy, 0);
            chk($sformatf("cmd%0d_op", i), mem_op, 0);
            chk($sformatf("cmd%0d_txv", i), tx_valid, 0);
        end

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_op", mem_op, 0);

        send4(8'h01, 32'h0000_0020);
        chk("addr_idle", busy, 0);
        req_q.push_back('{32'h20, 4'hF, 32'hAABB_CCDD});
        send4(8'h04, 32'hAABB_CCDD);
        chk("wr_op_edge", mem_op, 1);
        serve(3, 32'h0);
        do_read(32'h24, 32'h1122_3344, 1'b0, 1'b1);

        send4(8'h01, 32'h0000_0020);
        do_read(32'h20, 32'hAABB_CCDD, 1'b1, 1'b0);

        send(8'h01);
        send(8'h34);
        send(8'h12);
        repeat (T - 1) tick();
        chk("tmo_before", busy, 1);
        tick();
        chk("tmo_after", busy, 0);
        do_read(32'h24, 32'h5566_7788, 1'b0, 1'b0);

        send(8'h01);
        send(8'h78);
        send(8'h56);
        repeat (T - 1) tick();
        send(8'h34);
        chk("tmo_byte_wins", busy, 1);
        send(8'h12);
        chk("tmo_frame_done", busy, 0);
        do_read(32'h1234_5678, 32'hCAFE_F00D, 1'b1, 1'b0);

        send4(8'h01, 32'hFFFF_FFFC);
        req_q.push_back('{32'hFFFF_FFFC, 4'hF, 32'h0000_0001});
        send4(8'h04, 32'h0000_0001);
        serve(0, 32'h0);
        do_read(32'h0, 32'h0BAD_BEEF, 1'b0, 1'b0);

        send(8'h02);
        send4(8'h04, 32'hDDCC_BBAA);
        chk("midop_op", mem_op, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_mem");

        send(8'h02);
        req_q.push_back('{32'h0, 4'h0, 32'h0});
        send(8'h05);
        serve(0, 32'h1234_ABCD);
        chk("midtx_txv", tx_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_tx");

        req_q.push_back('{32'h0, 4'hF, 32'h0102_0304});
        send4(8'h04, 32'h0102_0304);
        serve(2, 32'h0);
        do_read(32'h4, 32'h8765_4321, 1'b1, 1'b0);
        chk("req_q_left", req_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
